// File: rtl/video_timing.sv
// Raster timing generator: pixel/line counters at half the clock rate, with
// registered blanking, sync and event pulses aligned to the counters.
module video_timing #(
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 288,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_LEN   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       h_half,
    output logic [8:0] h_cnt,
    output logic [8:0] v_cnt,
    output logic       hblank,
    output logic       vblank,
    output logic       cmpblk2,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       line_start,
    output logic       vblank_irq,
    output logic       frame_start
);

    if (!(H_ACTIVE < H_SYNC_START &&
          H_SYNC_START + H_SYNC_LEN <= H_TOTAL &&
          H_TOTAL <= 512)) begin : g_h_param_illegal
        $error("video_timing: illegal horizontal timing parameters");
    end

    if (!(V_ACTIVE < V_SYNC_START &&
          V_SYNC_START + V_SYNC_LEN <= V_TOTAL &&
          V_TOTAL <= 512)) begin : g_v_param_illegal
        $error("video_timing: illegal vertical timing parameters");
    end

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] H_SS   = 9'(H_SYNC_START);
    localparam logic [9:0] H_SE   = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic [8:0] V_SS   = 9'(V_SYNC_START);
    localparam logic [9:0] V_SE   = 10'(V_SYNC_START + V_SYNC_LEN);

    logic       h_half_nx;
    logic [8:0] h_cnt_nx;
    logic [8:0] v_cnt_nx;
    logic       line_wrap;
    logic       hblank_nx;
    logic       vblank_nx;
    logic       hsync_n_nx;
    logic       vsync_n_nx;
    logic       line_start_nx;
    logic       vblank_irq_nx;
    logic       frame_start_nx;

    // Decodes look at the next counter values so every output register
    // changes on the same edge as the counters it describes.
    always_comb begin
        h_half_nx = ~h_half;
        h_cnt_nx  = h_cnt;
        v_cnt_nx  = v_cnt;
        line_wrap = 1'b0;

        if (h_half) begin
            if (h_cnt == H_LAST) begin
                h_cnt_nx  = '0;
                line_wrap = 1'b1;
                if (v_cnt == V_LAST) begin
                    v_cnt_nx = '0;
                end else begin
                    v_cnt_nx = v_cnt + 9'd1;
                end
            end else begin
                h_cnt_nx = h_cnt + 9'd1;
            end
        end

        hblank_nx      = (h_cnt_nx >= H_ACT);
        vblank_nx      = (v_cnt_nx >= V_ACT);
        hsync_n_nx     = !((h_cnt_nx >= H_SS) && ({1'b0, h_cnt_nx} < H_SE));
        vsync_n_nx     = !((v_cnt_nx >= V_SS) && ({1'b0, v_cnt_nx} < V_SE));
        line_start_nx  = line_wrap;
        vblank_irq_nx  = line_wrap && (v_cnt_nx == V_ACT);
        frame_start_nx = line_wrap && (v_cnt_nx == 9'd0);
    end

    // Pulses are cleared on disabled clocks; since the counters do not move
    // while ena is low, an event cannot be re-reported when ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_half      <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            cmpblk2     <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            line_start  <= 1'b0;
            vblank_irq  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ena) begin
            h_half      <= h_half_nx;
            h_cnt       <= h_cnt_nx;
            v_cnt       <= v_cnt_nx;
            hblank      <= hblank_nx;
            vblank      <= vblank_nx;
            cmpblk2     <= hblank_nx | vblank_nx;
            hsync_n     <= hsync_n_nx;
            vsync_n     <= vsync_n_nx;
            line_start  <= line_start_nx;
            vblank_irq  <= vblank_irq_nx;
            frame_start <= frame_start_nx;
        end else begin
            line_start  <= 1'b0;
            vblank_irq  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: default-geometry instance for line-level vectors,
// small-geometry instance for whole-frame, random-enable and reset cases.
module tb_video_timing;

    localparam int SHT = 24, SHA = 12, SHSS = 16, SHSL = 4;
    localparam int SVT = 10, SVA = 6, SVSS = 7, SVSL = 2;
    localparam int SFR = SHT * SVT * 2;

    typedef struct packed {
        logic       half;
        logic [8:0] h;
        logic [8:0] v;
        logic       hb;
        logic       vb;
        logic       cb;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       vi;
        logic       fs;
    } out_t;

    typedef struct {
        int         t;
        logic       half;
        logic [8:0] h;
        logic [8:0] v;
        logic       hb;
        logic       hs;
        logic       ls;
        logic       cb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena_a = 1'b0;
    logic ena_b = 1'b0;

    logic       a_half, a_hb, a_vb, a_cb, a_hs, a_vs, a_ls, a_vi, a_fs;
    logic [8:0] a_h, a_v;
    logic       b_half, b_hb, b_vb, b_cb, b_hs, b_vs, b_ls, b_vi, b_fs;
    logic [8:0] b_h, b_v;

    int checks = 0;
    int errors = 0;
    int ta = 0, tbc = 0;
    bit la = 0, lb = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_timing u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a),
        .h_half(a_half), .h_cnt(a_h), .v_cnt(a_v),
        .hblank(a_hb), .vblank(a_vb), .cmpblk2(a_cb),
        .hsync_n(a_hs), .vsync_n(a_vs),
        .line_start(a_ls), .vblank_irq(a_vi), .frame_start(a_fs)
    );

    video_timing #(
        .H_TOTAL(SHT), .H_ACTIVE(SHA), .H_SYNC_START(SHSS), .H_SYNC_LEN(SHSL),
        .V_TOTAL(SVT), .V_ACTIVE(SVA), .V_SYNC_START(SVSS), .V_SYNC_LEN(SVSL)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b),
        .h_half(b_half), .h_cnt(b_h), .v_cnt(b_v),
        .hblank(b_hb), .vblank(b_vb), .cmpblk2(b_cb),
        .hsync_n(b_hs), .vsync_n(b_vs),
        .line_start(b_ls), .vblank_irq(b_vi), .frame_start(b_fs)
    );

    out_t oa, ob;
    assign oa = '{a_half, a_h, a_v, a_hb, a_vb, a_cb, a_hs, a_vs, a_ls, a_vi, a_fs};
    assign ob = '{b_half, b_h, b_v, b_hb, b_vb, b_cb, b_hs, b_vs, b_ls, b_vi, b_fs};

    // Reference: position follows directly from the count of enabled edges t.
    function automatic out_t model(int t, bit en, int ht, int ha, int hss, int hsl,
                                   int vt, int va, int vss, int vsl);
        out_t o;
        int pix, h, v;
        bit pul;
        pix = t / 2;
        h = pix % ht;
        v = (pix / ht) % vt;
        pul = en && (t > 0) && (t % 2 == 0) && (h == 0);
        o.half = (t % 2) == 1;
        o.h = 9'(h);
        o.v = 9'(v);
        o.hb = h >= ha;
        o.vb = v >= va;
        o.cb = o.hb | o.vb;
        o.hs = !(h >= hss && h < hss + hsl);
        o.vs = !(v >= vss && v < vss + vsl);
        o.ls = pul;
        o.vi = pul && (v == va);
        o.fs = pul && (v == 0);
        return o;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("half=%0d h=%0d v=%0d hb=%0d vb=%0d cb=%0d hs=%0d vs=%0d ls=%0d vi=%0d fs=%0d",
                         o.half, o.h, o.v, o.hb, o.vb, o.cb, o.hs, o.vs, o.ls, o.vi, o.fs);
    endfunction

    task automatic cmp_out(string nm, out_t got, out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {%s} expected {%s}", nm, fmt(got), fmt(exp));
        end
    endtask

    task automatic cmp_int(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_a(string nm);
        cmp_out(nm, oa, model(ta, la, 384, 256, 288, 32, 264, 224, 240, 4));
    endtask

    task automatic check_b(string nm);
        cmp_out(nm, ob, model(tbc, lb, SHT, SHA, SHSS, SHSL, SVT, SVA, SVSS, SVSL));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit ea, input bit eb);
        ena_a = ea;
        ena_b = eb;
        @(posedge clk);
        if (rst_n && ea) ta++;
        if (rst_n && eb) tbc++;
        la = ea;
        lb = eb;
        @(negedge clk);
    endtask

    vec_t vecs[14];
    int hs_low_a, n_ls, n_fs, n_vi, vs_low, cb_low, fs_cyc0, fs_period, pulse_dis, guard;
    bit found;

    initial begin
        vecs[0]  = '{1,    1'b1, 9'd0,   9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2,    1'b0, 9'd1,   9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{511,  1'b1, 9'd255, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{512,  1'b0, 9'd256, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{575,  1'b1, 9'd287, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{576,  1'b0, 9'd288, 9'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{639,  1'b1, 9'd319, 9'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{640,  1'b0, 9'd320, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{767,  1'b1, 9'd383, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{768,  1'b0, 9'd0,   9'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{769,  1'b1, 9'd0,   9'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4607, 1'b1, 9'd383, 9'd5, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{4608, 1'b0, 9'd0,   9'd6, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{4609, 1'b1, 9'd0,   9'd6, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state, with clocks running and ena high.
        @(negedge clk);
        step(1, 1);
        step(1, 1);
        cmp_out("reset_a", oa, model(0, 0, 384, 256, 288, 32, 264, 224, 240, 4));
        cmp_out("reset_b", ob, model(0, 0, SHT, SHA, SHSS, SHSL, SVT, SVA, SVSS, SVSL));
        ta = 0; tbc = 0;
        rst_n = 1'b1;

        // Default geometry: vector table along lines 0..6.
        hs_low_a = 0;
        for (int i = 0; i < 14; i++) begin
            while (ta < vecs[i].t) begin
                step(1, 0);
                check_a("model_a");
                if (ta >= 768 && ta < 1536 && a_hs == 1'b0) hs_low_a++;
            end
            checks++;
            if (a_half !== vecs[i].half || a_h !== vecs[i].h || a_v !== vecs[i].v ||
                a_hb !== vecs[i].hb || a_hs !== vecs[i].hs || a_ls !== vecs[i].ls ||
                a_cb !== vecs[i].cb) begin
                errors++;
                $display("FAIL vec%0d t=%0d got half=%0d h=%0d v=%0d hb=%0d hs=%0d ls=%0d cb=%0d expected half=%0d h=%0d v=%0d hb=%0d hs=%0d ls=%0d cb=%0d",
                         i, vecs[i].t, a_half, a_h, a_v, a_hb, a_hs, a_ls, a_cb,
                         vecs[i].half, vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].hs,
                         vecs[i].ls, vecs[i].cb);
            end
        end
        cmp_int("hsync_low_clks_line1", hs_low_a, 64);

        // Small geometry: two full frames with ena held high.
        n_ls = 0; n_fs = 0; n_vi = 0; vs_low = 0; cb_low = 0; fs_cyc0 = -1; fs_period = 0;
        while (tbc < 2 * SFR) begin
            step(0, 1);
            check_b("model_b_frames");
            n_ls += int'(b_ls);
            n_vi += int'(b_vi);
            if (b_vi && b_v != 9'(SVA)) cmp_int("vblank_irq_line", int'(b_v), SVA);
            if (!b_vs) vs_low++;
            if (!b_cb) cb_low++;
            if (b_fs) begin
                n_fs++;
                if (fs_cyc0 >= 0) fs_period = cyc - fs_cyc0;
                fs_cyc0 = cyc;
            end
        end
        cmp_int("frame_start_count", n_fs, 2);
        cmp_int("frame_period", fs_period, SFR);
        cmp_int("vblank_irq_count", n_vi, 2);
        cmp_int("line_start_count", n_ls, 2 * SVT);
        cmp_int("vsync_low_clks", vs_low, 2 * SVSL * SHT * 2);
        cmp_int("cmpblk2_low_clks", cb_low, 2 * SHA * SVA * 2);

        // Random enable on both instances across two more small frames.
        n_ls = 0; n_fs = 0; n_vi = 0; pulse_dis = 0; guard = 0;
        while (tbc < 4 * SFR && guard < 10 * SFR) begin
            step(1'($urandom % 2), 1'($urandom % 2));
            guard++;
            check_a("model_a_rand");
            check_b("model_b_rand");
            n_ls += int'(b_ls);
            n_fs += int'(b_fs);
            n_vi += int'(b_vi);
            if (!lb && (b_ls || b_fs || b_vi)) pulse_dis++;
            if (!la && (a_ls || a_fs || a_vi)) pulse_dis++;
        end
        cmp_int("rand_reached_end", int'(tbc >= 4 * SFR), 1);
        cmp_int("rand_line_start_count", n_ls, 2 * SVT);
        cmp_int("rand_frame_start_count", n_fs, 2);
        cmp_int("rand_vblank_irq_count", n_vi, 2);
        cmp_int("pulse_while_disabled", pulse_dis, 0);

        // Asynchronous reset between edges while both syncs are active.
        found = 0; guard = 0;
        while (!found && guard < 2 * SFR) begin
            step(0, 1);
            guard++;
            check_b("model_b_seek");
            found = ((tbc / 2) % SHT == SHSS + 1) && (((tbc / 2) / SHT) % SVT == SVSS);
        end
        cmp_int("seek_sync_position", int'(found), 1);
        cmp_int("sync_active_before_reset", int'({b_hs, b_vs}), 0);
        #2 rst_n = 1'b0;
        #1;
        ta = 0; tbc = 0; la = 0; lb = 0;
        cmp_out("async_reset_b", ob, model(0, 0, SHT, SHA, SHSS, SHSL, SVT, SVA, SVSS, SVSL));
        cmp_out("async_reset_a", oa, model(0, 0, 384, 256, 288, 32, 264, 224, 240, 4));
        @(negedge clk);
        step(1, 1);
        cmp_out("reset_hold_b", ob, model(0, 0, SHT, SHA, SHSS, SHSL, SVT, SVA, SVSS, SVSL));
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 1);
            check_a("restart_a");
            check_b("restart_b");
        end
        cmp_int("restart_pos_b", int'({b_half, b_h}), int'({1'b1, 9'd1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_TOTAL, default 384: pixels per line, counted 0..H_TOTAL-1.
REQ-002 Parameter H_ACTIVE, default 256: visible pixels per line, 0..H_ACTIVE-1.
REQ-003 Parameter H_SYNC_START, default 288: first pixel with hsync_n low.
REQ-004 Parameter H_SYNC_LEN, default 32: hsync_n low width, in pixels.
REQ-005 Parameter V_TOTAL, default 264: lines per frame, counted 0..V_TOTAL-1.
REQ-006 Parameter V_ACTIVE, default 224: visible lines, 0..V_ACTIVE-1.
REQ-007 Parameter V_SYNC_START, default 240: first line with vsync_n low.
REQ-008 Parameter V_SYNC_LEN, default 4: vsync_n low width, in lines.
REQ-009 clk  in  1  single clock, running at twice the pixel rate; all logic on rising edge.
REQ-010 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-011 ena  in  1  clock enable; when low, all state holds.
REQ-012 h_half  out  1  pixel phase: 0 = first half, 1 = second half; drives the palette stage.
REQ-013 h_cnt  out  9  current pixel index.
REQ-014 v_cnt  out  9  current line index.
REQ-015 hblank  out  1  high when h_cnt >= H_ACTIVE.
REQ-016 vblank  out  1  high when v_cnt >= V_ACTIVE.
REQ-017 cmpblk2  out  1  composite blank, hblank OR vblank.
REQ-018 hsync_n  out  1  active-low horizontal sync.
REQ-019 vsync_n  out  1  active-low vertical sync.
REQ-020 line_start  out  1  one-clk pulse when a new line begins.
REQ-021 vblank_irq  out  1  one-clk pulse when vertical blank begins.
REQ-022 frame_start  out  1  one-clk pulse when a new frame begins.

Function
REQ-023 All outputs SHALL be registered. Every decode SHALL be computed from next-state counter values, so decodes align with h_cnt, v_cnt and h_half on the same edge.
REQ-024 On each clk edge with ena=1, h_half SHALL toggle.
REQ-025 On an edge with ena=1 and h_half=1, h_cnt SHALL increment. Each pixel therefore lasts exactly 2 enabled clks.
REQ-026 On an edge where h_cnt=H_TOTAL-1 and h_cnt would increment, h_cnt SHALL wrap to 0 and v_cnt SHALL increment.
REQ-027 On an edge where v_cnt=V_TOTAL-1 and v_cnt would increment, v_cnt SHALL wrap to 0.
REQ-028 hsync_n SHALL be 0 exactly while H_SYNC_START <= h_cnt < H_SYNC_START+H_SYNC_LEN; otherwise 1.
REQ-029 vsync_n SHALL be 0 exactly while V_SYNC_START <= v_cnt < V_SYNC_START+V_SYNC_LEN; otherwise 1. vsync_n changes only on line-wrap edges.
REQ-030 line_start SHALL be 1 for one clk, on the edge where h_cnt becomes 0 and h_half becomes 0.
REQ-031 vblank_irq SHALL be 1 for one clk, on the edge where v_cnt becomes V_ACTIVE (h_cnt becomes 0).
REQ-032 frame_start SHALL be 1 for one clk, on the edge where h_cnt and v_cnt both become 0.
REQ-033 When ena=0, the pulse outputs line_start, vblank_irq and frame_start SHALL be 0. All other outputs SHALL hold.
REQ-034 Each pulse SHALL fire exactly once per event, even if ena drops and returns.
REQ-035 Parameter legality is a required condition, checked by an elaboration-time assertion:
- H_ACTIVE < H_SYNC_START
- H_SYNC_START+H_SYNC_LEN <= H_TOTAL <= 512
- the same relations for the vertical parameters.

Reset
REQ-036 While rst_n=0, regardless of clk:
- h_half=0, h_cnt=0, v_cnt=0
- hblank=0, vblank=0, cmpblk2=0
- hsync_n=1, vsync_n=1
- line_start=0, vblank_irq=0, frame_start=0
REQ-037 The first enabled edge after rst_n deassertion SHALL set h_half=1 with h_cnt=0. No pulse SHALL be emitted for the reset-state position.
REQ-038 Reset asserted mid-line or mid-frame SHALL return all state to the REQ-036 values immediately. No partial pulse or sync SHALL persist.

Verification
REQ-039 Reset release, ena=1 -> clks 1,2 give (h_half,h_cnt) = (1,0), (0,1). Pixel 255 -> 256 on the h_half=1 edge raises hblank and cmpblk2 on that same edge.
REQ-040 Line wrap: (h_cnt=383, h_half=1, v_cnt=5) edge -> h_cnt=0, v_cnt=6, h_half=0, line_start=1 for exactly 1 clk. hsync_n low for exactly 64 clks per line, covering pixels 288-319.
REQ-041 Full frame at defaults:
- frame_start period = 202752 clks
- exactly one vblank_irq per frame, at v_cnt=224
- vsync_n low for lines 240-243 (3072 clks)
- cmpblk2 low for exactly 224*256*2 clks per frame.
REQ-042 ena toggled pseudo-randomly (about 50%) over 2 frames -> counter sequence is identical to the ena=1 run once disabled clks are removed. Pulses never occur with ena=0, and the pulse count is unchanged.
REQ-043 rst_n asserted asynchronously at h_cnt=300, v_cnt=241, between clk edges -> outputs reach the REQ-036 values before the next edge, with hsync_n and vsync_n released to 1. After release, the sequence restarts per REQ-037.
